cernbe_vme_split32: RTL and testbench

- Host-side bridge that sits upstream of the generated cern-be-vme register banks.
- Accepts 32-bit single-word read/write requests from a local master and issues two sequential 16-bit cern-be-vme accesses: high half first, low half second.
- Drives the bank's VMEAddr/VMERdMem/VMEWrMem/VMEWrData and consumes VMERdData/VMERdDone/VMEWrDone.
- Reassembles read data and returns a single ack to the host.

---
 rtl/cernbe_split_pkg.sv | 18 +
 rtl/cernbe_split_wdog.sv | 43 ++++
 rtl/cernbe_vme_split32.sv | 194 +++++++++++++++++++
 tb/tb_cernbe_vme_split32.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cernbe_split_pkg.sv
// cernbe_split_pkg: shared types and constants for the 32-to-16 bit cern-be-vme split bridge.
//   state_e      : bridge FSM states
//   HALF_HI/LO   : VMEAddr bit 0 selecting the high/low 16-bit half
//   TIMEOUT_DATA : read data returned on an aborted transaction
package cernbe_split_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    ACK  = 2'd3
  } state_e;

  localparam logic        HALF_HI      = 1'b0;
  localparam logic        HALF_LO      = 1'b1;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/cernbe_split_wdog.sv
// cernbe_split_wdog: done watchdog for the split bridge.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : (re)start counting; the first counted cycle reads 1
//   clear      : stop and zero the counter
//   expire_c   : high while the count equals TIMEOUT (combinational)
// TIMEOUT must be at least 1.
module cernbe_split_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Zero means idle; counting saturates at TIMEOUT until cleared or restarted.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CNT_W'(1);
    end else if (clear) begin
      cnt_d = '0;
    end else if ((cnt_q != '0) && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/cernbe_vme_split32.sv
// cernbe_vme_split32: turns one 32-bit host read/write into two sequential 16-bit
// cern-be-vme bank accesses (high half first), reassembling read data.
//   clk, rst_n                    : clock, synchronous active-low reset
//   h_adr/h_we/h_req/h_wdat       : host request (single-cycle strobe)
//   h_rdat/h_ack/h_err/h_busy     : host response, all registered
//   VMEAddr/VMEWrData/VMERdMem/VMEWrMem : bank access, all registered
//   VMERdData/VMERdDone/VMEWrDone : bank response
// Optional macro CERNBE_SPLIT_TIMEOUT_EN adds a done watchdog (TIMEOUT cycles) that
// aborts with h_err and TIMEOUT_DATA; without it h_err is tied low.
module cernbe_vme_split32
  import cernbe_split_pkg::*;
#(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-3:0] h_adr,
  input  logic              h_we,
  input  logic              h_req,
  input  logic [31:0]       h_wdat,
  output logic [31:0]       h_rdat,
  output logic              h_ack,
  output logic              h_err,
  output logic              h_busy,
  output logic [ADDR_W-2:0] VMEAddr,
  output logic [15:0]       VMEWrData,
  output logic              VMERdMem,
  output logic              VMEWrMem,
  input  logic [15:0]       VMERdData,
  input  logic              VMERdDone,
  input  logic              VMEWrDone
);

  state_e            state_q, state_d;
  logic [ADDR_W-3:0] adr_q, adr_d;
  logic              we_q, we_d;
  logic [15:0]       wdat_lo_q, wdat_lo_d;
  logic [15:0]       hi_q, hi_d;
  logic [31:0]       h_rdat_q, h_rdat_d;
  logic              h_ack_q, h_ack_d;
  logic              h_busy_q, h_busy_d;
  logic [ADDR_W-2:0] vme_addr_q, vme_addr_d;
  logic [15:0]       vme_wr_data_q, vme_wr_data_d;
  logic              vme_rd_mem_q, vme_rd_mem_d;
  logic              vme_wr_mem_q, vme_wr_mem_d;
  logic              done_c;

  // Only the done matching the latched direction counts.
  assign done_c = we_q ? VMEWrDone : VMERdDone;

`ifdef CERNBE_SPLIT_TIMEOUT_EN
  logic expire_c, wd_start_c, wd_clear_c;
  logic h_err_q, h_err_d;

  // Restart on every strobe, stop whenever the host is acknowledged.
  assign wd_start_c = vme_rd_mem_d | vme_wr_mem_d;
  assign wd_clear_c = h_ack_d;

  cernbe_split_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (wd_start_c),
    .clear    (wd_clear_c),
    .expire_c (expire_c)
  );

  assign h_err = h_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign h_err          = 1'b0;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    adr_d         = adr_q;
    we_d          = we_q;
    wdat_lo_d     = wdat_lo_q;
    hi_d          = hi_q;
    h_rdat_d      = h_rdat_q;
    h_ack_d       = 1'b0;
    h_busy_d      = h_busy_q;
    vme_addr_d    = vme_addr_q;
    vme_wr_data_d = vme_wr_data_q;
    vme_rd_mem_d  = 1'b0;
    vme_wr_mem_d  = 1'b0;
`ifdef CERNBE_SPLIT_TIMEOUT_EN
    h_err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (h_req) begin
          adr_d         = h_adr;
          we_d          = h_we;
          wdat_lo_d     = h_wdat[15:0];
          vme_addr_d    = {h_adr, HALF_HI};
          vme_wr_data_d = h_wdat[31:16];
          vme_wr_mem_d  = h_we;
          vme_rd_mem_d  = ~h_we;
          h_busy_d      = 1'b1;
          state_d       = HI;
        end
      end
      HI: begin
        if (done_c) begin
          if (!we_q) hi_d = VMERdData;
          vme_addr_d    = {adr_q, HALF_LO};
          vme_wr_data_d = wdat_lo_q;
          vme_wr_mem_d  = we_q;
          vme_rd_mem_d  = ~we_q;
          state_d       = LO;
        end
`ifdef CERNBE_SPLIT_TIMEOUT_EN
        else if (expire_c) begin
          h_rdat_d = TIMEOUT_DATA;
          h_err_d  = 1'b1;
          h_ack_d  = 1'b1;
          state_d  = ACK;
        end
`endif
      end
      LO: begin
        if (done_c) begin
          h_rdat_d = we_q ? 32'h0 : {hi_q, VMERdData};
          h_ack_d  = 1'b1;
          state_d  = ACK;
        end
`ifdef CERNBE_SPLIT_TIMEOUT_EN
        else if (expire_c) begin
          h_rdat_d = TIMEOUT_DATA;
          h_err_d  = 1'b1;
          h_ack_d  = 1'b1;
          state_d  = ACK;
        end
`endif
      end
      ACK: begin
        // One-cycle gap after the ack; requests here are still dropped.
        h_busy_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      adr_q         <= '0;
      we_q          <= 1'b0;
      wdat_lo_q     <= '0;
      hi_q          <= '0;
      h_rdat_q      <= '0;
      h_ack_q       <= 1'b0;
      h_busy_q      <= 1'b0;
      vme_addr_q    <= '0;
      vme_wr_data_q <= '0;
      vme_rd_mem_q  <= 1'b0;
      vme_wr_mem_q  <= 1'b0;
`ifdef CERNBE_SPLIT_TIMEOUT_EN
      h_err_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      adr_q         <= adr_d;
      we_q          <= we_d;
      wdat_lo_q     <= wdat_lo_d;
      hi_q          <= hi_d;
      h_rdat_q      <= h_rdat_d;
      h_ack_q       <= h_ack_d;
      h_busy_q      <= h_busy_d;
      vme_addr_q    <= vme_addr_d;
      vme_wr_data_q <= vme_wr_data_d;
      vme_rd_mem_q  <= vme_rd_mem_d;
      vme_wr_mem_q  <= vme_wr_mem_d;
`ifdef CERNBE_SPLIT_TIMEOUT_EN
      h_err_q       <= h_err_d;
`endif
    end
  end

  assign h_rdat    = h_rdat_q;
  assign h_ack     = h_ack_q;
  assign h_busy    = h_busy_q;
  assign VMEAddr   = vme_addr_q;
  assign VMEWrData = vme_wr_data_q;
  assign VMERdMem  = vme_rd_mem_q;
  assign VMEWrMem  = vme_wr_mem_q;

endmodule

// File: tb/tb_cernbe_vme_split32.sv
// Directed bench for cernbe_vme_split32 with a small cern-be-vme bank model whose
// done latency (0 = same cycle as strobe, N = strobe+N, 255 = never) is selectable.
module tb_cernbe_vme_split32;

  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned TIMEOUT   = 16;
  localparam int unsigned NCAP      = 128;
  localparam int unsigned LAT_NEVER = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-3:0] h_adr = '0;
  logic              h_we = 1'b0;
  logic              h_req = 1'b0;
  logic [31:0]       h_wdat = '0;
  logic [31:0]       h_rdat;
  logic              h_ack, h_err, h_busy;
  logic [ADDR_W-2:0] VMEAddr;
  logic [15:0]       VMEWrData;
  logic              VMERdMem, VMEWrMem;
  logic [15:0]       VMERdData;
  logic              VMERdDone, VMEWrDone;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cernbe_vme_split32 #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .h_adr     (h_adr),
    .h_we      (h_we),
    .h_req     (h_req),
    .h_wdat    (h_wdat),
    .h_rdat    (h_rdat),
    .h_ack     (h_ack),
    .h_err     (h_err),
    .h_busy    (h_busy),
    .VMEAddr   (VMEAddr),
    .VMEWrData (VMEWrData),
    .VMERdMem  (VMERdMem),
    .VMEWrMem  (VMEWrMem),
    .VMERdData (VMERdData),
    .VMERdDone (VMERdDone),
    .VMEWrDone (VMEWrDone)
  );

  // ---------------- bank model ----------------
  logic [15:0] mem [4];
  int unsigned lat = 1;
  int unsigned rem = 0;
  logic        done_r = 1'b0;
  logic        pend_we = 1'b0;
  logic        inj_rd = 1'b0;
  logic        inj_wr = 1'b0;
  logic        pre_go = 1'b0;
  logic [1:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  assign VMERdData = mem[VMEAddr];
  assign VMERdDone = ((lat == 0) ? VMERdMem : (done_r & ~pend_we)) | inj_rd;
  assign VMEWrDone = ((lat == 0) ? VMEWrMem : (done_r &  pend_we)) | inj_wr;

  always @(posedge clk) begin
    done_r <= 1'b0;
    if (pre_go) mem[pre_addr] <= pre_data;
    if (VMERdMem || VMEWrMem) begin
      pend_we <= VMEWrMem;
      if (VMEWrMem) mem[VMEAddr] <= VMEWrData;
      if (lat == 1) done_r <= 1'b1;
      else if (lat > 1 && lat != LAT_NEVER) rem <= lat - 1;
    end else if (rem == 1) begin
      done_r <= 1'b1;
      rem    <= 0;
    end else if (rem > 1) begin
      rem <= rem - 1;
    end
  end

  task automatic bank_load(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pre_addr = a; pre_data = d; pre_go = 1'b1;
    @(posedge clk); #1;
    pre_go = 1'b0;
  endtask

  // ---------------- per-cycle capture ----------------
  logic        rd_s [NCAP];
  logic        wr_s [NCAP];
  logic        ack_s [NCAP];
  logic        err_s [NCAP];
  logic        busy_s [NCAP];
  logic [1:0]  addr_s [NCAP];
  logic [15:0] wd_s [NCAP];
  logic [31:0] rdat_s [NCAP];

  // Request in cycle 0, record outputs for cycles 1..n; req_mask bit c re-raises
  // h_req in cycle c with a different address/direction/data.
  task automatic run_txn(input logic [ADDR_W-3:0] adr, input logic we, input logic [31:0] wdat,
                         input int n, input logic [NCAP-1:0] req_mask);
    @(posedge clk); #1;
    h_adr = adr; h_we = we; h_wdat = wdat; h_req = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      h_req = req_mask[c];
      if (req_mask[c]) begin
        h_adr = ~adr; h_we = ~we; h_wdat = ~wdat;
      end
      rd_s[c] = VMERdMem;  wr_s[c] = VMEWrMem;
      ack_s[c] = h_ack;    err_s[c] = h_err;   busy_s[c] = h_busy;
      addr_s[c] = VMEAddr; wd_s[c] = VMEWrData; rdat_s[c] = h_rdat;
    end
    h_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({h_rdat, h_ack, h_err, h_busy, VMEAddr, VMEWrData, VMERdMem, VMEWrMem} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdat=%h ack=%b err=%b busy=%b addr=%h wd=%h rd=%b wr=%b required all zero",
               h_rdat, h_ack, h_err, h_busy, VMEAddr, VMEWrData, VMERdMem, VMEWrMem);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    int nwr, nrd, nack, ackc;
    lat = 2;
    run_txn(1'b0, 1'b1, 32'h12345678, 12, '0);
    nwr = 0; nrd = 0; nack = 0; ackc = 0;
    for (int c = 1; c <= 12; c++) begin
      nwr += int'(wr_s[c]); nrd += int'(rd_s[c]);
      if (ack_s[c]) begin nack++; ackc = c; end
    end
    checks++; if ({wr_s[1], addr_s[1], wd_s[1]} !== {1'b1, 2'b00, 16'h1234}) begin errors++;
      $display("FAIL wr_hi_strobe got wr=%b addr=%b data=%h required 1 00 1234", wr_s[1], addr_s[1], wd_s[1]); end
    checks++; if ({addr_s[3], wd_s[3]} !== {2'b00, 16'h1234}) begin errors++;
      $display("FAIL wr_hi_hold got addr=%b data=%h required 00 1234", addr_s[3], wd_s[3]); end
    checks++; if ({wr_s[4], addr_s[4], wd_s[4]} !== {1'b1, 2'b01, 16'h5678}) begin errors++;
      $display("FAIL wr_lo_strobe got wr=%b addr=%b data=%h required 1 01 5678", wr_s[4], addr_s[4], wd_s[4]); end
    checks++; if (nwr !== 2 || nrd !== 0) begin errors++;
      $display("FAIL wr_strobe_count got wr=%0d rd=%0d required 2 0", nwr, nrd); end
    checks++; if (nack !== 1 || ackc !== 7) begin errors++;
      $display("FAIL wr_ack got count=%0d cycle=%0d required 1 at 7", nack, ackc); end
    checks++; if (err_s[7] !== 1'b0) begin errors++;
      $display("FAIL wr_err got %b required 0", err_s[7]); end
    checks++; if ({busy_s[7], busy_s[8]} !== 2'b10) begin errors++;
      $display("FAIL wr_busy got %b%b required 10", busy_s[7], busy_s[8]); end
    // Read the 32-bit register back through the bridge.
    lat = 1;
    run_txn(1'b0, 1'b0, 32'h0, 8, '0);
    checks++; if ({ack_s[5], rdat_s[5]} !== {1'b1, 32'h12345678}) begin errors++;
      $display("FAIL wr_readback got ack=%b rdat=%h required 1 12345678", ack_s[5], rdat_s[5]); end
  endtask

  task automatic test_read();
    int nrd;
    bank_load(2'd0, 16'hCAFE);
    bank_load(2'd1, 16'hBEEF);
    lat = 1;
    run_txn(1'b0, 1'b0, 32'h0, 10, '0);
    nrd = 0;
    for (int c = 1; c <= 10; c++) nrd += int'(rd_s[c]);
    checks++; if ({rd_s[1], rd_s[2], rd_s[3], addr_s[1], addr_s[3]} !== {3'b101, 2'b00, 2'b01}) begin errors++;
      $display("FAIL rd_strobes got rd1..3=%b%b%b addr1=%b addr3=%b required 101 00 01",
               rd_s[1], rd_s[2], rd_s[3], addr_s[1], addr_s[3]); end
    checks++; if (nrd !== 2) begin errors++;
      $display("FAIL rd_strobe_count got %0d required 2", nrd); end
    checks++; if ({ack_s[4], ack_s[5], ack_s[6]} !== 3'b010) begin errors++;
      $display("FAIL rd_ack_timing got %b%b%b required 010", ack_s[4], ack_s[5], ack_s[6]); end
    checks++; if (rdat_s[5] !== 32'hCAFEBEEF) begin errors++;
      $display("FAIL rd_data got %h required cafebeef", rdat_s[5]); end
    checks++; if ({busy_s[5], busy_s[6], err_s[5]} !== 3'b100) begin errors++;
      $display("FAIL rd_busy_err got busy=%b%b err=%b required 10 0", busy_s[5], busy_s[6], err_s[5]); end
    checks++; if (rdat_s[10] !== 32'hCAFEBEEF) begin errors++;
      $display("FAIL rd_data_hold got %h required cafebeef", rdat_s[10]); end
  endtask

  task automatic test_busy_drop();
    int nrd, nwr, nack;
    logic [NCAP-1:0] m;
    m = '0; m[2] = 1'b1; m[4] = 1'b1; m[5] = 1'b0;
    lat = 1;
    run_txn(1'b0, 1'b0, 32'h0, 12, m);
    nrd = 0; nwr = 0; nack = 0;
    for (int c = 1; c <= 12; c++) begin
      nrd += int'(rd_s[c]); nwr += int'(wr_s[c]); nack += int'(ack_s[c]);
    end
    checks++; if (nrd !== 2 || nwr !== 0) begin errors++;
      $display("FAIL busy_strobes got rd=%0d wr=%0d required 2 0", nrd, nwr); end
    checks++; if (nack !== 1 || ack_s[5] !== 1'b1) begin errors++;
      $display("FAIL busy_ack got count=%0d ack5=%b required 1 1", nack, ack_s[5]); end
    checks++; if ({addr_s[1], addr_s[3]} !== {2'b00, 2'b01}) begin errors++;
      $display("FAIL busy_addr got %b %b required 00 01", addr_s[1], addr_s[3]); end
    checks++; if (rdat_s[5] !== 32'hCAFEBEEF) begin errors++;
      $display("FAIL busy_data got %h required cafebeef", rdat_s[5]); end
  endtask

  task automatic test_same_cycle_done();
    bank_load(2'd2, 16'h0A0B);
    bank_load(2'd3, 16'h0C0D);
    lat = 0;
    run_txn(1'b1, 1'b0, 32'h0, 8, '0);
    checks++; if ({rd_s[1], rd_s[2], rd_s[3], addr_s[1], addr_s[2]} !== {3'b110, 2'b10, 2'b11}) begin errors++;
      $display("FAIL same_strobes got rd1..3=%b%b%b addr=%b %b required 110 10 11",
               rd_s[1], rd_s[2], rd_s[3], addr_s[1], addr_s[2]); end
    checks++; if ({ack_s[2], ack_s[3], ack_s[4]} !== 3'b010) begin errors++;
      $display("FAIL same_ack got %b%b%b required 010", ack_s[2], ack_s[3], ack_s[4]); end
    checks++; if (rdat_s[3] !== 32'h0A0B0C0D) begin errors++;
      $display("FAIL same_data got %h required 0a0b0c0d", rdat_s[3]); end
    lat = 1;
  endtask

  task automatic test_timeout();
    int nrd, nack;
    lat = LAT_NEVER;
`ifdef CERNBE_SPLIT_TIMEOUT_EN
    run_txn(1'b0, 1'b0, 32'h0, 24, '0);
    nrd = 0; nack = 0;
    for (int c = 1; c <= 24; c++) begin nrd += int'(rd_s[c]); nack += int'(ack_s[c]); end
    checks++; if (nrd !== 1) begin errors++;
      $display("FAIL to_strobes got %0d required 1", nrd); end
    checks++; if ({ack_s[16], ack_s[17], err_s[17]} !== 3'b011 || nack !== 1) begin errors++;
      $display("FAIL to_ack got ack16=%b ack17=%b err17=%b count=%0d required 0 1 1 1",
               ack_s[16], ack_s[17], err_s[17], nack); end
    checks++; if (rdat_s[17] !== 32'hDEADBEEF) begin errors++;
      $display("FAIL to_data got %h required deadbeef", rdat_s[17]); end
    checks++; if ({busy_s[17], busy_s[18]} !== 2'b10) begin errors++;
      $display("FAIL to_busy got %b%b required 10", busy_s[17], busy_s[18]); end
`else
    run_txn(1'b0, 1'b0, 32'h0, 110, '0);
    nrd = 0; nack = 0;
    for (int c = 1; c <= 110; c++) begin
      nrd += int'(rd_s[c]); nack += int'(ack_s[c]);
      if (busy_s[c] !== 1'b1) nack += 100;
    end
    checks++; if (nrd !== 1 || nack !== 0) begin errors++;
      $display("FAIL to_wait got strobes=%0d ack_or_idle=%0d required 1 0", nrd, nack); end
    checks++; if (h_err !== 1'b0) begin errors++;
      $display("FAIL to_err_tied got %b required 0", h_err); end
    // Recover the stuck transaction.
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
`endif
    lat = 1;
  endtask

  task automatic test_wrong_done_and_reset();
    int nrd, nack;
    lat = LAT_NEVER;
    inj_wr = 1'b1;
    run_txn(1'b0, 1'b0, 32'h0, 6, '0);
    inj_wr = 1'b0;
    nrd = 0; nack = 0;
    for (int c = 1; c <= 6; c++) begin nrd += int'(rd_s[c]); nack += int'(ack_s[c]); end
    checks++; if (nrd !== 1 || nack !== 0 || busy_s[6] !== 1'b1) begin errors++;
      $display("FAIL wrong_done got strobes=%0d acks=%0d busy=%b required 1 0 1", nrd, nack, busy_s[6]); end
    // Reset while waiting in HI.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({h_rdat, h_ack, h_err, h_busy, VMEAddr, VMEWrData, VMERdMem, VMEWrMem} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got rdat=%h ack=%b busy=%b addr=%h wd=%h rd=%b wr=%b required all zero",
               h_rdat, h_ack, h_busy, VMEAddr, VMEWrData, VMERdMem, VMEWrMem);
    end
    // Late done after reset release must be ignored.
    inj_rd = 1'b1;
    @(posedge clk); #1;
    inj_rd = 1'b0;
    nack = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      nack += int'(h_ack) + int'(h_busy) + int'(VMERdMem) + int'(VMEWrMem);
    end
    checks++; if (nack !== 0) begin errors++;
      $display("FAIL late_done got activity=%0d required 0", nack); end
    lat = 1;
    run_txn(1'b0, 1'b0, 32'h0, 8, '0);
    checks++; if ({rd_s[1], rd_s[3], ack_s[5], rdat_s[5]} !== {3'b111, 32'hCAFEBEEF}) begin errors++;
      $display("FAIL post_reset_read got rd1=%b rd3=%b ack5=%b rdat=%h required 1 1 1 cafebeef",
               rd_s[1], rd_s[3], ack_s[5], rdat_s[5]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy_drop();
    test_same_cycle_done();
    test_timeout();
    test_wrong_done_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
